// File: rtl/divisor_clock_generator.sv
// divisor_clock_generator: turns a 32-bit half-period divisor into a glitch-free divided clock and rise tick
// Divisor updates are taken only at half-period boundaries, so no runt phase can appear.
module divisor_clock_generator #(
   parameter logic [31:0] DEFAULT_DIVISOR = 32'd1136,
   parameter logic [31:0] MIN_DIVISOR     = 32'd1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [31:0] frequency_divisor,
   output logic        divided_clk,
   output logic        tick,
   output logic [31:0] active_divisor
);
   localparam logic [31:0] RESET_DIVISOR = (DEFAULT_DIVISOR < MIN_DIVISOR) ? MIN_DIVISOR : DEFAULT_DIVISOR;
   logic [31:0] counter;
   logic [31:0] sampled_divisor;
   logic        boundary;
   // active_divisor is never below MIN_DIVISOR, so the -1 cannot wrap
   always_comb begin
      boundary        = counter == active_divisor - 32'd1;
      sampled_divisor = (frequency_divisor < MIN_DIVISOR) ? MIN_DIVISOR : frequency_divisor;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         counter        <= '0;
         divided_clk    <= 1'b0;
         tick           <= 1'b0;
         active_divisor <= RESET_DIVISOR;
      end else begin
         tick <= enable && boundary && !divided_clk;
         if (enable) begin
            counter <= boundary ? '0 : counter + 32'd1;
            if (boundary) begin
               divided_clk    <= ~divided_clk;
               active_divisor <= sampled_divisor;
            end
         end
      end
   end
endmodule

// File: tb/tb_divisor_clock_generator.sv
// tb_divisor_clock_generator: randomized and directed checks against an absolute-edge-count reference model
module tb_divisor_clock_generator;
   localparam logic [31:0] DEF = 32'd1136;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [31:0] frequency_divisor = DEF;
   logic        divided_clk;
   logic        tick;
   logic [31:0] active_divisor;
   int checks = 0;
   int fails = 0;
   // model: toggles are scheduled at absolute enabled-edge indices
   longint      en_edges;
   longint      next_toggle;
   logic        m_clk;
   logic        m_tick;
   logic [31:0] m_div;

   always #5 clk = ~clk;

   divisor_clock_generator #(.DEFAULT_DIVISOR(DEF), .MIN_DIVISOR(32'd1)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .enable(enable),
      .frequency_divisor(frequency_divisor),
      .divided_clk(divided_clk),
      .tick(tick),
      .active_divisor(active_divisor)
   );

   task automatic model_reset;
      en_edges    = 0;
      next_toggle = DEF;
      m_clk       = 1'b0;
      m_tick      = 1'b0;
      m_div       = DEF;
   endtask

   task automatic step;
      @(posedge clk);
      m_tick = 1'b0;
      if (enable) begin
         en_edges++;
         if (en_edges == next_toggle) begin
            m_tick      = !m_clk;
            m_clk       = !m_clk;
            m_div       = (frequency_divisor == 0) ? 32'd1 : frequency_divisor;
            next_toggle = en_edges + m_div;
         end
      end
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (divided_clk !== 1'b0 || tick !== 1'b0 || active_divisor !== DEF) begin
         fails++;
         $display("FAIL reset: got clk=%b tick=%b div=%0d want 0 0 %0d", divided_clk, tick, active_divisor, DEF);
      end
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_steady;
      int last_tick = -1;
      int period = 0;
      enable = 1'b1;
      frequency_divisor = 32'd4;
      for (int i = 0; i < 1136 + 40; i++) begin
         step();
         checks++;
         if (divided_clk !== m_clk || tick !== m_tick || active_divisor !== m_div) begin
            fails++;
            $display("FAIL steady cyc %0d: got %b %b %0d want %b %b %0d", i, divided_clk, tick, active_divisor, m_clk, m_tick, m_div);
         end
         if (i == 1134 || i == 1135) begin
            checks++;
            if (divided_clk !== (i == 1135)) begin
               fails++;
               $display("FAIL first_rise edge %0d: got %b want %b", i + 1, divided_clk, i == 1135);
            end
         end
         if (tick === 1'b1) begin
            if (last_tick >= 0) period = i - last_tick;
            last_tick = i;
         end
      end
      checks++;
      if (period != 8) begin
         fails++;
         $display("FAIL steady_period: got %0d want 8", period);
      end
   endtask

   task automatic test_mid_change;
      logic prev;
      int   k = 0;
      frequency_divisor = 32'd4;
      prev = m_clk;
      while (!(prev == 1'b1 && m_clk == 1'b0) && k < 40) begin
         prev = m_clk;
         step();
         k++;
      end
      if (k >= 40) begin
         fails++;
         $display("FAIL mid_sync: no falling boundary within 40 cycles, got clk=%b", divided_clk);
      end
      for (int i = 0; i < 24; i++) begin
         if (i == 2) frequency_divisor = 32'd6;
         if (i == 5) frequency_divisor = 32'd10;
         if (i == 6) frequency_divisor = 32'd6;
         step();
         checks++;
         if (divided_clk !== m_clk || tick !== m_tick || active_divisor !== m_div) begin
            fails++;
            $display("FAIL mid_change cyc %0d: got %b %b %0d want %b %b %0d", i, divided_clk, tick, active_divisor, m_clk, m_tick, m_div);
         end
      end
      checks++;
      if (active_divisor !== 32'd6) begin
         fails++;
         $display("FAIL mid_pulse_ignored: got div=%0d want 6", active_divisor);
      end
   endtask

   task automatic test_freeze;
      logic held;
      logic prev;
      int   k = 0;
      frequency_divisor = 32'd5;
      prev = m_clk;
      while (prev == m_clk && k < 40) begin
         prev = m_clk;
         step();
         k++;
      end
      repeat (2) step();
      held = m_clk;
      enable = 1'b0;
      for (int i = 0; i < 7; i++) begin
         frequency_divisor = $urandom_range(0, 20);
         step();
         checks++;
         if (divided_clk !== held || tick !== 1'b0 || active_divisor !== m_div) begin
            fails++;
            $display("FAIL freeze cyc %0d: got %b %b %0d want %b 0 %0d", i, divided_clk, tick, active_divisor, held, m_div);
         end
      end
      enable = 1'b1;
      frequency_divisor = 32'd5;
      for (int i = 0; i < 12; i++) begin
         step();
         checks++;
         if (divided_clk !== m_clk || tick !== m_tick || active_divisor !== m_div) begin
            fails++;
            $display("FAIL resume cyc %0d: got %b %b %0d want %b %b %0d", i, divided_clk, tick, active_divisor, m_clk, m_tick, m_div);
         end
      end
   endtask

   task automatic test_clamp;
      logic prev;
      frequency_divisor = 32'd0;
      for (int i = 0; i < 16; i++) begin
         prev = divided_clk;
         step();
         checks++;
         if (divided_clk !== m_clk || tick !== m_tick || active_divisor !== m_div) begin
            fails++;
            $display("FAIL clamp cyc %0d: got %b %b %0d want %b %b %0d", i, divided_clk, tick, active_divisor, m_clk, m_tick, m_div);
         end
         if (i >= 8) begin
            checks++;
            if (active_divisor !== 32'd1 || divided_clk !== !prev || tick !== !prev) begin
               fails++;
               $display("FAIL clamp_toggle cyc %0d: got %b %b %0d want %b %b 1", i, divided_clk, tick, active_divisor, !prev, !prev);
            end
         end
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 1500; i++) begin
         enable = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 4) == 0) frequency_divisor = $urandom_range(0, 6);
         step();
         checks++;
         if (divided_clk !== m_clk || tick !== m_tick || active_divisor !== m_div) begin
            fails++;
            $display("FAIL random cyc %0d: got %b %b %0d want %b %b %0d", i, divided_clk, tick, active_divisor, m_clk, m_tick, m_div);
         end
      end
      enable = 1'b1;
   endtask

   task automatic test_async_reset;
      logic prev;
      int   k = 0;
      frequency_divisor = 32'd1140;
      prev = m_clk;
      while (!(prev == 1'b0 && m_clk == 1'b1 && m_div == 32'd1140) && k < 4000) begin
         prev = m_clk;
         step();
         k++;
      end
      if (k >= 4000) begin
         fails++;
         $display("FAIL async_sync: no 1140 high phase within 4000 cycles, got div=%0d", active_divisor);
      end
      repeat (600) step();
      checks++;
      if (divided_clk !== 1'b1 || active_divisor !== 32'd1140) begin
         fails++;
         $display("FAIL async_pre: got clk=%b div=%0d want 1 1140", divided_clk, active_divisor);
      end
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (divided_clk !== 1'b0 || tick !== 1'b0 || active_divisor !== DEF) begin
         fails++;
         $display("FAIL async_reset: got %b %b %0d want 0 0 %0d", divided_clk, tick, active_divisor, DEF);
      end
      model_reset();
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 1136 + 4; i++) begin
         step();
         checks++;
         if (divided_clk !== m_clk || tick !== m_tick || active_divisor !== m_div) begin
            fails++;
            $display("FAIL post_reset cyc %0d: got %b %b %0d want %b %b %0d", i, divided_clk, tick, active_divisor, m_clk, m_tick, m_div);
         end
         if (i == 1134 || i == 1135) begin
            checks++;
            if (divided_clk !== (i == 1135) || tick !== (i == 1135)) begin
               fails++;
               $display("FAIL post_reset_rise edge %0d: got clk=%b tick=%b want %b", i + 1, divided_clk, tick, i == 1135);
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_steady();
      test_mid_change();
      test_freeze();
      test_clamp();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
